cache_0_ctrl: RTL and testbench
===============================

Name: cache_0_ctrl

Overview:
Tag-lookup and miss-handling controller for cache 0, sitting directly upstream of the cache 0 tag RAM.
- Accepts CPU read/write requests, drives the tag RAM index, and compares the returned entry to resolve hit or miss.
- Sequences write-back of a dirty victim and refill over a request/acknowledge memory handshake.
- Writes updated tag, valid and dirty bits back into the tag RAM.
- Handles tag state only; the data array is out of scope.

Parameters:
AWIDTH, 3, index width; 8 sets; must match the tag RAM address width
TWIDTH, 12, tag width
OWIDTH, 1, block offset width
Derived localparam DWIDTH = TWIDTH+2 (tag entry width, 14); entry layout: bit 13 = valid, bit 12 = dirty, bits 11:0 = tag
Derived localparam CAW = TWIDTH+AWIDTH+OWIDTH (CPU address width, 16); cpu_addr = {tag, index, offset}

Ports:
clock  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high
cpu_req  in  1  request strobe; sampled only while cpu_ready=1
cpu_we  in  1  1 = write, 0 = read; latched with cpu_req
cpu_addr  in  CAW  request address; latched with cpu_req
cpu_ready  out  1  1 only in IDLE
cpu_resp_valid  out  1  one-cycle response pulse
cpu_hit  out  1  hit flag; valid while cpu_resp_valid=1
tag_addr  out  AWIDTH  tag RAM index
tag_wdata  out  DWIDTH  tag RAM write data
tag_we  out  1  tag RAM write enable
tag_rdata  in  DWIDTH  tag RAM read data, one cycle after tag_addr is sampled
mem_req  out  1  memory request, held until acknowledged
mem_we  out  1  1 = write-back, 0 = refill
mem_addr  out  CAW  block address, offset bits = 0
mem_ack  in  1  one-cycle acknowledge from memory
hit_count  out  16  hits (see Optional Feature)
miss_count  out  16  misses (see Optional Feature)

Behaviour:
- Reset values: state IDLE; cpu_ready=1; cpu_resp_valid=0; cpu_hit=0; tag_we=0; mem_req=0; mem_we=0; mem_addr=0; tag_addr=0; tag_wdata=0; counters=0.
- Tag RAM contents are not touched by reset.
- Request acceptance: cpu_req=1 in IDLE at edge N latches cpu_we, tag, index and drives tag_addr=index. cpu_req in any other state is ignored.
- tag_addr is held at the latched index for the whole transaction.
- IDLE: on accept, go to COMPARE.
- COMPARE (cycle N+1): tag_rdata is valid.
  - hit = valid && (tag_rdata[11:0] == latched tag); registered.
  - Read hit, or write hit with dirty=1: go to RESP.
  - Write hit with dirty=0: go to UPDATE with tag_wdata = {1,1,tag}.
  - Miss with victim valid && dirty: go to WB. mem_addr = {victim tag, index, 0}; mem_we=1.
  - Any other miss: go to FILL. mem_addr = {req tag, index, 0}; mem_we=0.
- WB: mem_req=1 until mem_ack. On ack, load the refill address, clear mem_we, go to FILL. mem_req stays 1 across the transition.
- FILL: mem_req=1 until mem_ack. On ack: mem_req=0, tag_wdata = {1, cpu_we, tag}, go to UPDATE.
- UPDATE: tag_we=1 for exactly one cycle, then go to RESP.
- RESP: cpu_resp_valid=1 and cpu_hit = registered hit for one cycle, then go to IDLE.
- Latency (accept edge = N):
  - read hit, or write hit dirty: resp at N+2
  - write hit clean: resp at N+3
  - miss: resp at (final ack cycle)+2
- mem_ack outside WB/FILL is ignored.
- mem_req never drops before ack. It is 0 in the cycle after the FILL ack.
- Reset mid-transaction: next state IDLE, mem_req=0 and tag_we=0 from the following cycle; no partial tag write.
- Back-to-back: a request may be accepted in the cycle after RESP.

Optional Feature:
CACHE_0_STATS_EN
- Defined: hit_count increments in COMPARE on a hit; miss_count increments in COMPARE on a miss. Both saturate at 16'hFFFF and clear on reset.
- Undefined: both outputs tied to 0 and no counter flops are generated.

Test Plan:
- Read hit: preload index 2 = 14'h2ABC; request read at 16'hABC4 at edge N -> resp_valid at N+2, hit=1, mem_req never asserted, tag_we never asserted.
- Write hit, clean line: same address, cpu_we=1 -> tag_we pulse with tag_addr=2 and tag_wdata=14'h3ABC; resp at N+3, hit=1.
- Dirty-victim miss: index 2 = 14'h3ABC; read 16'h1234; mem_ack after 3 cycles each -> first mem_req with mem_we=1, mem_addr=16'hABC4; then mem_we=0, mem_addr=16'h1234; then tag_we with 14'h2123; resp hit=0.
- Invalid-entry miss: index 5 = 0; write 16'h005A -> no write-back phase; fill at 16'h005A; tag_wdata=14'h3005; resp hit=0.
- Reset during FILL, with mem_req=1 -> mem_req=0 and cpu_ready=1 the next cycle; tag_we stays 0; the subsequent read of the old address behaves per the tag RAM contents.
- cpu_req toggled while busy is ignored; with CACHE_0_STATS_EN defined, after scenarios 1-4 -> hit_count=2, miss_count=2.

Source files
------------

// File: rtl/cache_0_ctrl.sv
// Cache 0 tag-lookup and miss-handling controller (tag state only, no data array).
// Optional hit/miss counters are built when CACHE_0_STATS_EN is defined.
`timescale 1ns/1ps
module cache_0_ctrl #(
   parameter int AWIDTH = 3,
   parameter int TWIDTH = 12,
   parameter int OWIDTH = 1,
   localparam int DWIDTH = TWIDTH + 2,
   localparam int CAW    = TWIDTH + AWIDTH + OWIDTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [CAW-1:0]    cpu_addr,
   output logic              cpu_ready,
   output logic              cpu_resp_valid,
   output logic              cpu_hit,
   output logic [AWIDTH-1:0] tag_addr,
   output logic [DWIDTH-1:0] tag_wdata,
   output logic              tag_we,
   input  logic [DWIDTH-1:0] tag_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [CAW-1:0]    mem_addr,
   input  logic              mem_ack,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_COMPARE, S_WB, S_FILL, S_UPDATE, S_RESP
   } state_t;

   state_t r_state, w_next;

   logic              r_we;
   logic [TWIDTH-1:0] r_tag;
   logic [AWIDTH-1:0] r_idx;
   logic              r_hit;
   logic [DWIDTH-1:0] r_tag_wdata;
   logic              r_mem_we;
   logic [CAW-1:0]    r_mem_addr;

   logic              w_accept;
   logic [TWIDTH-1:0] w_req_tag;
   logic [AWIDTH-1:0] w_req_idx;
   logic              w_valid;
   logic              w_dirty;
   logic              w_hit;
   logic              w_unused_ok;

   assign w_req_tag   = cpu_addr[CAW-1 -: TWIDTH];
   assign w_req_idx   = cpu_addr[OWIDTH +: AWIDTH];
   assign w_accept    = (r_state == S_IDLE) && cpu_req;
   assign w_valid     = tag_rdata[DWIDTH-1];
   assign w_dirty     = tag_rdata[TWIDTH];
   assign w_hit       = w_valid && (tag_rdata[TWIDTH-1:0] == r_tag);
   assign w_unused_ok = &{1'b0, cpu_addr[OWIDTH-1:0]};

   // Index goes to the tag RAM in the accept cycle so the entry is back for COMPARE.
   assign tag_addr  = w_accept ? w_req_idx : r_idx;
   assign tag_wdata = r_tag_wdata;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next         = r_state;
      cpu_ready      = 1'b0;
      cpu_resp_valid = 1'b0;
      cpu_hit        = 1'b0;
      tag_we         = 1'b0;
      mem_req        = 1'b0;
      case (r_state)
         S_IDLE: begin
            cpu_ready = 1'b1;
            if (cpu_req) w_next = S_COMPARE;
         end
         S_COMPARE: begin
            if (w_hit)                  w_next = (!r_we || w_dirty) ? S_RESP : S_UPDATE;
            else if (w_valid && w_dirty) w_next = S_WB;
            else                         w_next = S_FILL;
         end
         S_WB: begin
            mem_req = 1'b1;
            if (mem_ack) w_next = S_FILL;
         end
         S_FILL: begin
            mem_req = 1'b1;
            if (mem_ack) w_next = S_UPDATE;
         end
         S_UPDATE: begin
            tag_we = 1'b1;
            w_next = S_RESP;
         end
         S_RESP: begin
            cpu_resp_valid = 1'b1;
            cpu_hit        = r_hit;
            w_next         = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_we        <= 1'b0;
         r_tag       <= '0;
         r_idx       <= '0;
         r_hit       <= 1'b0;
         r_tag_wdata <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (cpu_req) begin
               r_we  <= cpu_we;
               r_tag <= w_req_tag;
               r_idx <= w_req_idx;
            end
            S_COMPARE: begin
               r_hit <= w_hit;
               if (w_hit) begin
                  r_tag_wdata <= {2'b11, r_tag};
               end else if (w_valid && w_dirty) begin
                  r_mem_addr <= {tag_rdata[TWIDTH-1:0], r_idx, {OWIDTH{1'b0}}};
                  r_mem_we   <= 1'b1;
               end else begin
                  r_mem_addr <= {r_tag, r_idx, {OWIDTH{1'b0}}};
                  r_mem_we   <= 1'b0;
               end
            end
            S_WB: if (mem_ack) begin
               r_mem_addr <= {r_tag, r_idx, {OWIDTH{1'b0}}};
               r_mem_we   <= 1'b0;
            end
            S_FILL: if (mem_ack) r_tag_wdata <= {1'b1, r_we, r_tag};
            default: ;
         endcase
      end
   end

`ifdef CACHE_0_STATS_EN
   logic [15:0] r_hit_count;
   logic [15:0] r_miss_count;

   // Counters saturate rather than wrap.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else if (r_state == S_COMPARE) begin
         if (w_hit && r_hit_count != 16'hFFFF)   r_hit_count  <= r_hit_count + 16'd1;
         if (!w_hit && r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`else
   assign hit_count  = 16'd0;
   assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_cache_0_ctrl.sv
// Directed bench for cache_0_ctrl with a synchronous tag RAM model and a delayed-ack memory.
`timescale 1ns/1ps
module tb_cache_0_ctrl;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [15:0] cpu_addr = 16'h0;
   logic        cpu_ready, cpu_resp_valid, cpu_hit;
   logic [2:0]  tag_addr;
   logic [13:0] tag_wdata, tag_rdata;
   logic        tag_we, mem_req, mem_we;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [15:0] hit_count, miss_count;

   cache_0_ctrl dut (
      .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid), .cpu_hit(cpu_hit),
      .tag_addr(tag_addr), .tag_wdata(tag_wdata), .tag_we(tag_we), .tag_rdata(tag_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // tag RAM model: registered read, preload port owned by the stimulus
   logic [13:0] tram [0:7];
   logic        pre_we = 1'b0;
   logic [2:0]  pre_addr = 3'd0;
   logic [13:0] pre_data = 14'h0;
   always @(posedge clock) begin
      if (pre_we)      tram[pre_addr] <= pre_data;
      else if (tag_we) tram[tag_addr] <= tag_wdata;
      tag_rdata <= tram[tag_addr];
   end

   // memory: acks each request 3 cycles after it is seen
   logic en_mem = 1'b1;
   int   wcnt = 0;
   always @(posedge clock) begin
      if (reset)                  begin mem_ack <= 1'b0; wcnt <= 0; end
      else if (mem_ack)           begin mem_ack <= 1'b0; wcnt <= 0; end
      else if (mem_req && en_mem) begin
         if (wcnt == 2) mem_ack <= 1'b1;
         else           wcnt <= wcnt + 1;
      end else wcnt <= 0;
   end

   // monitor
   logic        mon_clr = 1'b0;
   int          cyc_ctr = 0, last_ack = 0, resp_at = 0;
   int          tw_n = 0, log_n = 0, drop_err = 0, post_ack_err = 0;
   logic [2:0]  tw_addr = 3'd0;
   logic [13:0] tw_data = 14'h0;
   logic        log_we [0:3];
   logic [15:0] log_addr [0:3];
   logic        prev_req = 1'b0, prev_ack = 1'b0, prev_fill_ack = 1'b0, prev_rst = 1'b1;
   always @(posedge clock) begin
      cyc_ctr       <= cyc_ctr + 1;
      prev_req      <= mem_req;
      prev_ack      <= mem_ack;
      prev_fill_ack <= mem_ack && mem_req && !mem_we;
      prev_rst      <= reset;
      if (mon_clr) begin
         tw_n <= 0; log_n <= 0; drop_err <= 0; post_ack_err <= 0;
      end else begin
         if (tag_we) begin tw_n <= tw_n + 1; tw_addr <= tag_addr; tw_data <= tag_wdata; end
         if (mem_ack && mem_req && log_n < 4) begin
            log_we[log_n] <= mem_we; log_addr[log_n] <= mem_addr; log_n <= log_n + 1;
         end
         if (mem_ack) last_ack <= cyc_ctr;
         if (cpu_resp_valid) resp_at <= cyc_ctr;
         if (prev_req && !mem_req && !prev_ack && !prev_rst) drop_err <= drop_err + 1;
         if (prev_fill_ack && mem_req) post_ack_err <= post_ack_err + 1;
      end
   end

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic preload(input logic [2:0] a, input logic [13:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic clr_mon();
      mon_clr = 1'b1; tick(); mon_clr = 1'b0;
   endtask

   task automatic issue(input logic we, input logic [15:0] addr);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr;
      tick();
      cpu_req = 1'b0;
   endtask

   // cycles after the accept edge until cpu_resp_valid is seen (60 = gave up)
   task automatic wait_resp(output int cyc);
      cyc = 0;
      while (!cpu_resp_valid && cyc < 60) begin tick(); cyc++; end
   endtask

   task automatic test_reset();
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      n_cmp++; if (cpu_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", cpu_ready); end
      n_cmp++; if (cpu_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp got %b want 0", cpu_resp_valid); end
      n_cmp++; if ({mem_req, mem_we, tag_we} !== 3'b000) begin n_bad++; $display("FAIL rst_ctl got %b want 000", {mem_req, mem_we, tag_we}); end
      n_cmp++; if (mem_addr !== 16'h0) begin n_bad++; $display("FAIL rst_maddr got %h want 0000", mem_addr); end
      n_cmp++; if ({tag_addr, tag_wdata} !== 17'h0) begin n_bad++; $display("FAIL rst_tag got %h/%h want 0/0", tag_addr, tag_wdata); end
      n_cmp++; if ({hit_count, miss_count} !== 32'h0) begin n_bad++; $display("FAIL rst_cnt got %h/%h want 0/0", hit_count, miss_count); end
   endtask

   task automatic test_read_hit();
      int cyc;
      preload(3'd2, 14'h2ABC); clr_mon();
      issue(1'b0, 16'hABC4);
      n_cmp++; if (tag_rdata !== 14'h2ABC) begin n_bad++; $display("FAIL rh_rdata got %h want 2abc", tag_rdata); end
      wait_resp(cyc);
      n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL rh_lat got %0d want 1", cyc); end
      n_cmp++; if (cpu_hit !== 1'b1) begin n_bad++; $display("FAIL rh_hit got %b want 1", cpu_hit); end
      tick();
      n_cmp++; if (log_n !== 0 || tw_n !== 0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL rh_side got acks=%0d twe=%0d req=%b want 0 0 0", log_n, tw_n, mem_req); end
   endtask

   task automatic test_write_hit_clean();
      int cyc;
      clr_mon();
      issue(1'b1, 16'hABC4);
      wait_resp(cyc);
      n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL wh_lat got %0d want 2", cyc); end
      n_cmp++; if (cpu_hit !== 1'b1) begin n_bad++; $display("FAIL wh_hit got %b want 1", cpu_hit); end
      n_cmp++; if (tw_n !== 1 || tw_addr !== 3'd2 || tw_data !== 14'h3ABC) begin n_bad++; $display("FAIL wh_tagwr got n=%0d a=%0d d=%h want 1 2 3abc", tw_n, tw_addr, tw_data); end
      n_cmp++; if (log_n !== 0) begin n_bad++; $display("FAIL wh_mem got %0d want 0", log_n); end
      tick();
   endtask

   // busy-time cpu_req toggling rides along on this scenario
   task automatic test_dirty_miss();
      int cyc;
      clr_mon();
      issue(1'b0, 16'h1234);
      cyc = 0;
      while (!cpu_resp_valid && cyc < 60) begin
         tick(); cyc++;
         if (!cpu_resp_valid) begin cpu_req = cyc[0]; cpu_we = 1'b1; cpu_addr = 16'h0F0F; end
      end
      cpu_req = 1'b0;
      n_cmp++; if (cpu_resp_valid !== 1'b1 || cpu_hit !== 1'b0) begin n_bad++; $display("FAIL dm_resp got v=%b h=%b want 1 0", cpu_resp_valid, cpu_hit); end
      tick();
      n_cmp++; if (log_n !== 2) begin n_bad++; $display("FAIL dm_nreq got %0d want 2", log_n); end
      n_cmp++; if (log_we[0] !== 1'b1 || log_addr[0] !== 16'hABC4) begin n_bad++; $display("FAIL dm_wb got we=%b a=%h want 1 abc4", log_we[0], log_addr[0]); end
      n_cmp++; if (log_we[1] !== 1'b0 || log_addr[1] !== 16'h1234) begin n_bad++; $display("FAIL dm_fill got we=%b a=%h want 0 1234", log_we[1], log_addr[1]); end
      n_cmp++; if (tw_n !== 1 || tw_data !== 14'h2123) begin n_bad++; $display("FAIL dm_tagwr got n=%0d d=%h want 1 2123", tw_n, tw_data); end
      n_cmp++; if (resp_at - last_ack !== 2) begin n_bad++; $display("FAIL dm_lat got %0d want 2", resp_at - last_ack); end
      n_cmp++; if (drop_err !== 0 || post_ack_err !== 0) begin n_bad++; $display("FAIL dm_req got drop=%0d post=%0d want 0 0", drop_err, post_ack_err); end
      tick();
      n_cmp++; if (cpu_ready !== 1'b1 || tw_n !== 1) begin n_bad++; $display("FAIL dm_ignore got rdy=%b twe=%0d want 1 1", cpu_ready, tw_n); end
   endtask

   task automatic test_invalid_miss();
      int cyc;
      preload(3'd5, 14'h0000); clr_mon();
      issue(1'b1, 16'h005A);
      wait_resp(cyc);
      n_cmp++; if (cpu_resp_valid !== 1'b1 || cpu_hit !== 1'b0) begin n_bad++; $display("FAIL im_resp got v=%b h=%b want 1 0", cpu_resp_valid, cpu_hit); end
      tick();
      n_cmp++; if (log_n !== 1 || log_we[0] !== 1'b0 || log_addr[0] !== 16'h005A) begin n_bad++; $display("FAIL im_fill got n=%0d we=%b a=%h want 1 0 005a", log_n, log_we[0], log_addr[0]); end
      n_cmp++; if (tw_n !== 1 || tw_addr !== 3'd5 || tw_data !== 14'h3005) begin n_bad++; $display("FAIL im_tagwr got n=%0d a=%0d d=%h want 1 5 3005", tw_n, tw_addr, tw_data); end
`ifdef CACHE_0_STATS_EN
      n_cmp++; if (hit_count !== 16'd2 || miss_count !== 16'd2) begin n_bad++; $display("FAIL stats4 got %0d/%0d want 2/2", hit_count, miss_count); end
`else
      n_cmp++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin n_bad++; $display("FAIL stats_off got %0d/%0d want 0/0", hit_count, miss_count); end
`endif
   endtask

   task automatic test_reset_mid_fill();
      int cyc;
      preload(3'd6, 14'h2555); clr_mon();
      en_mem = 1'b0;
      issue(1'b0, 16'h777C);
      cyc = 0;
      while (!mem_req && cyc < 10) begin tick(); cyc++; end
      tick(); tick();
      n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h777C) begin n_bad++; $display("FAIL rf_fill got req=%b we=%b a=%h want 1 0 777c", mem_req, mem_we, mem_addr); end
      reset = 1'b1; tick(); reset = 1'b0;
      n_cmp++; if (mem_req !== 1'b0 || cpu_ready !== 1'b1 || tag_we !== 1'b0) begin n_bad++; $display("FAIL rf_abort got req=%b rdy=%b twe=%b want 0 1 0", mem_req, cpu_ready, tag_we); end
      en_mem = 1'b1;
      tick(); tick();
      n_cmp++; if (tw_n !== 0) begin n_bad++; $display("FAIL rf_notagwr got %0d want 0", tw_n); end
      issue(1'b0, 16'h555C);
      wait_resp(cyc);
      n_cmp++; if (cyc !== 1 || cpu_hit !== 1'b1) begin n_bad++; $display("FAIL rf_reread got lat=%0d h=%b want 1 1", cyc, cpu_hit); end
      tick();
   endtask

   task automatic test_back_to_back();
      int cyc;
      issue(1'b0, 16'h555C);
      wait_resp(cyc);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h555C;
      tick();
      n_cmp++; if (cpu_ready !== 1'b1 || cpu_resp_valid !== 1'b0) begin n_bad++; $display("FAIL bb_idle got rdy=%b v=%b want 1 0", cpu_ready, cpu_resp_valid); end
      tick();
      cpu_req = 1'b0;
      n_cmp++; if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL bb_accept got %b want 0", cpu_ready); end
      wait_resp(cyc);
      n_cmp++; if (cyc !== 1 || cpu_hit !== 1'b1) begin n_bad++; $display("FAIL bb_resp got lat=%0d h=%b want 1 1", cyc, cpu_hit); end
      tick();
`ifdef CACHE_0_STATS_EN
      n_cmp++; if (hit_count !== 16'd3 || miss_count !== 16'd0) begin n_bad++; $display("FAIL stats_end got %0d/%0d want 3/0", hit_count, miss_count); end
`endif
   endtask

   initial begin
      test_reset();
      test_read_hit();
      test_write_hit_clean();
      test_dirty_miss();
      test_invalid_miss();
      test_reset_mid_fill();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
